// File: rtl/dds_sweep_pkg.sv
// dds_sweep_pkg: shared mode/state encodings and default widths for the DDS sweep sequencer.
package dds_sweep_pkg;
  localparam int SWEEP_WIDTH   = 32;
  localparam int SWEEP_DWELL_W = 24;
  typedef enum logic [1:0] {SWEEP_UP = 2'd0, SWEEP_DOWN = 2'd1, SWEEP_SAW = 2'd2, SWEEP_TRI = 2'd3} mode_t;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// dwell_timer: loadable down-counter that pulses expire_o once every max(value,1) enabled cycles.
module dwell_timer
  import dds_sweep_pkg::*;
#(
  parameter int DWELL_W = SWEEP_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] value_i,
  output logic               expire_o
);
  logic [DWELL_W-1:0] rld_q, rld_d, cnt_q, cnt_d;
  // Counting D-1 down to 0 makes a dwell of 0 behave exactly like 1.
  always_comb begin
    rld_d = load_i ? ((value_i == '0) ? '0 : value_i - DWELL_W'(1)) : rld_q;
    cnt_d = load_i ? rld_d : (en_i ? ((cnt_q == '0) ? rld_q : cnt_q - DWELL_W'(1)) : cnt_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rld_q <= '0;
      cnt_q <= '0;
    end else begin
      rld_q <= rld_d;
      cnt_q <= cnt_d;
    end
  end
  assign expire_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS tuning word between two endpoints with a programmable dwell,
// supporting single up/down, sawtooth and triangle sweeps.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int WIDTH   = SWEEP_WIDTH,
  parameter int DWELL_W = SWEEP_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [1:0]         mode_i,
  input  logic [WIDTH-1:0]   f_start_i,
  input  logic [WIDTH-1:0]   f_stop_i,
  input  logic [WIDTH-1:0]   f_delta_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [WIDTH-1:0]   step_out_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               marker_o,
  output logic               cfg_err_o
);
  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, dl_q, dl_d, step_q, step_d;
  logic             dir_q, dir_d, done_q, done_d, mk_q, mk_d, err_q, err_d;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] up_nxt, dn_nxt;
  logic             at_end, accept, bad, expire;
  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (state_q == RUN),
    .load_i   (accept && !bad),
    .value_i  (dwell_i),
    .expire_o (expire)
  );
  // Endpoint clamps are evaluated one bit wider so large deltas never wrap.
  always_comb begin
    up_sum = {1'b0, step_q} + {1'b0, dl_q};
    up_nxt = (up_sum >= {1'b0, hi_q}) ? hi_q : up_sum[WIDTH-1:0];
    dn_nxt = ({1'b0, step_q} < {1'b0, lo_q} + {1'b0, dl_q}) ? lo_q : step_q - dl_q;
    at_end = dir_q ? (step_q == hi_q) : (step_q == lo_q);
    accept = (state_q == IDLE) && start_i && !stop_i;
    bad    = (f_delta_i == '0) || (f_start_i > f_stop_i);
    state_d = state_q;
    mode_d  = mode_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dl_d    = dl_q;
    step_d  = step_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    mk_d    = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE) begin
      if (accept && bad) begin
        err_d = 1'b1;
      end else if (accept) begin
        state_d = RUN;
        mode_d  = mode_t'(mode_i);
        lo_d    = f_start_i;
        hi_d    = f_stop_i;
        dl_d    = f_delta_i;
        step_d  = (mode_t'(mode_i) == SWEEP_DOWN) ? f_stop_i : f_start_i;
        dir_d   = (mode_t'(mode_i) != SWEEP_DOWN);
        mk_d    = 1'b1;
      end
    end else if (stop_i) begin
      state_d = IDLE;
    end else if (expire) begin
      if (!at_end) begin
        step_d = dir_q ? up_nxt : dn_nxt;
      end else if (mode_q == SWEEP_UP || mode_q == SWEEP_DOWN) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else if (mode_q == SWEEP_SAW) begin
        step_d = lo_q;
        mk_d   = 1'b1;
      end else begin
        dir_d  = !dir_q;
        step_d = dir_q ? dn_nxt : up_nxt;
        mk_d   = !dir_q || (lo_q == hi_q);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= SWEEP_UP;
      lo_q    <= '0;
      hi_q    <= '0;
      dl_q    <= '0;
      step_q  <= '0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
      mk_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dl_q    <= dl_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      mk_q    <= mk_d;
      err_q   <= err_d;
    end
  end
  assign step_out_o = step_q;
  assign busy_o     = (state_q == RUN);
  assign done_o     = done_q;
  assign marker_o   = mk_q;
  assign cfg_err_o  = err_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: scoreboard bench; expected per-cycle outputs are queued by each scenario
// and compared on every falling edge.
module tb_dds_sweep_ctrl;
  typedef struct packed {
    logic [31:0] step;
    logic        busy;
    logic        done;
    logic        mk;
    logic        err;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [31:0] f_start_i = '0, f_stop_i = '0, f_delta_i = '0;
  logic [23:0] dwell_i = '0;
  logic [31:0] step_out_o;
  logic        busy_o, done_o, marker_o, cfg_err_o;
  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  dds_sweep_ctrl #(.WIDTH(32), .DWELL_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .mode_i     (mode_i),
    .f_start_i  (f_start_i),
    .f_stop_i   (f_stop_i),
    .f_delta_i  (f_delta_i),
    .dwell_i    (dwell_i),
    .step_out_o (step_out_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .marker_o   (marker_o),
    .cfg_err_o  (cfg_err_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++;
      if ({step_out_o, busy_o, done_o, marker_o, cfg_err_o} !== e) begin
        n_bad++;
        $display("FAIL outputs @cyc %0d: got step=%0h busy=%b done=%b marker=%b cfg_err=%b, want step=%0h busy=%b done=%b marker=%b cfg_err=%b",
                 cyc, step_out_o, busy_o, done_o, marker_o, cfg_err_o, e.step, e.busy, e.done, e.mk, e.err);
      end
    end
  end
  task automatic push(input int n, input logic [31:0] s, input logic b, input logic d, input logic m, input logic er = 1'b0);
    for (int i = 0; i < n; i++) sb_q.push_back('{step: s, busy: b, done: d, mk: m, err: er});
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      $display("FAIL drain: %0d expected entries never consumed", sb_q.size());
      $fatal(1);
    end
  endtask
  task automatic go(input logic [1:0] m, input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] dl, input logic [23:0] dw);
    @(negedge clk);
    #1;
    mode_i = m;
    f_start_i = lo;
    f_stop_i = hi;
    f_delta_i = dl;
    dwell_i = dw;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask
  task automatic test_reset();
    #1;
    push(2, 32'd0, 1'b0, 1'b0, 1'b0);
    drain();
    rst_n = 1'b1;
    go(2'd2, 32'd0, 32'd30, 32'd10, 24'd1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    push(1, 32'd0, 1'b0, 1'b0, 1'b0);
    drain();
    rst_n = 1'b1;
    push(4, 32'd0, 1'b0, 1'b0, 1'b0);
    drain();
  endtask
  task automatic test_single_up();
    go(2'd0, 32'd100, 32'd130, 32'd10, 24'd3);
    push(1, 32'd100, 1'b1, 1'b0, 1'b1);
    push(2, 32'd100, 1'b1, 1'b0, 1'b0);
    push(3, 32'd110, 1'b1, 1'b0, 1'b0);
    push(3, 32'd120, 1'b1, 1'b0, 1'b0);
    push(3, 32'd130, 1'b1, 1'b0, 1'b0);
    push(1, 32'd130, 1'b0, 1'b1, 1'b0);
    push(1, 32'd130, 1'b0, 1'b0, 1'b0);
    drain();
  endtask
  task automatic test_clamp();
    go(2'd0, 32'd0, 32'd25, 32'd10, 24'd1);
    push(1, 32'd0, 1'b1, 1'b0, 1'b1);
    push(1, 32'd10, 1'b1, 1'b0, 1'b0);
    push(1, 32'd20, 1'b1, 1'b0, 1'b0);
    push(1, 32'd25, 1'b1, 1'b0, 1'b0);
    push(1, 32'd25, 1'b0, 1'b1, 1'b0);
    push(1, 32'd25, 1'b0, 1'b0, 1'b0);
    drain();
    go(2'd0, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 24'd0);
    push(1, 32'd0, 1'b1, 1'b0, 1'b1);
    push(1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    push(1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    push(1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    drain();
  endtask
  task automatic test_single_down();
    go(2'd1, 32'd100, 32'd130, 32'd10, 24'd2);
    push(1, 32'd130, 1'b1, 1'b0, 1'b1);
    push(1, 32'd130, 1'b1, 1'b0, 1'b0);
    push(2, 32'd120, 1'b1, 1'b0, 1'b0);
    push(2, 32'd110, 1'b1, 1'b0, 1'b0);
    push(2, 32'd100, 1'b1, 1'b0, 1'b0);
    push(1, 32'd100, 1'b0, 1'b1, 1'b0);
    drain();
  endtask
  task automatic test_degenerate();
    go(2'd0, 32'd77, 32'd77, 32'd5, 24'd3);
    push(1, 32'd77, 1'b1, 1'b0, 1'b1);
    push(2, 32'd77, 1'b1, 1'b0, 1'b0);
    push(1, 32'd77, 1'b0, 1'b1, 1'b0);
    drain();
    go(2'd2, 32'd77, 32'd77, 32'd5, 24'd2);
    for (int i = 0; i < 3; i++) begin
      push(1, 32'd77, 1'b1, 1'b0, 1'b1);
      push(1, 32'd77, 1'b1, 1'b0, 1'b0);
    end
    drain();
    stop_i = 1'b1;
    push(2, 32'd77, 1'b0, 1'b0, 1'b0);
    drain();
    stop_i = 1'b0;
  endtask
  task automatic test_triangle();
    go(2'd3, 32'd0, 32'd20, 32'd10, 24'd2);
    start_i = 1'b1;
    mode_i = 2'd0;
    f_start_i = 32'd7;
    f_delta_i = 32'd1;
    push(1, 32'd0, 1'b1, 1'b0, 1'b1);
    push(1, 32'd0, 1'b1, 1'b0, 1'b0);
    push(2, 32'd10, 1'b1, 1'b0, 1'b0);
    push(2, 32'd20, 1'b1, 1'b0, 1'b0);
    push(2, 32'd10, 1'b1, 1'b0, 1'b0);
    push(2, 32'd0, 1'b1, 1'b0, 1'b0);
    push(1, 32'd10, 1'b1, 1'b0, 1'b1);
    push(1, 32'd10, 1'b1, 1'b0, 1'b0);
    push(2, 32'd20, 1'b1, 1'b0, 1'b0);
    push(2, 32'd10, 1'b1, 1'b0, 1'b0);
    push(2, 32'd0, 1'b1, 1'b0, 1'b0);
    push(1, 32'd10, 1'b1, 1'b0, 1'b1);
    push(1, 32'd10, 1'b1, 1'b0, 1'b0);
    drain();
    start_i = 1'b0;
    stop_i = 1'b1;
    push(2, 32'd10, 1'b0, 1'b0, 1'b0);
    drain();
    stop_i = 1'b0;
  endtask
  task automatic test_saw_stop();
    go(2'd2, 32'd5, 32'd15, 32'd5, 24'd1);
    for (int i = 0; i < 2; i++) begin
      push(1, 32'd5, 1'b1, 1'b0, 1'b1);
      push(1, 32'd10, 1'b1, 1'b0, 1'b0);
      push(1, 32'd15, 1'b1, 1'b0, 1'b0);
    end
    push(1, 32'd5, 1'b1, 1'b0, 1'b1);
    drain();
    stop_i = 1'b1;
    push(2, 32'd5, 1'b0, 1'b0, 1'b0);
    drain();
    start_i = 1'b1;
    mode_i = 2'd0;
    f_start_i = 32'd1;
    f_stop_i = 32'd9;
    f_delta_i = 32'd1;
    push(2, 32'd5, 1'b0, 1'b0, 1'b0);
    drain();
    start_i = 1'b0;
    stop_i = 1'b0;
  endtask
  task automatic test_cfg_err();
    go(2'd0, 32'd10, 32'd40, 32'd0, 24'd1);
    push(1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    push(2, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    go(2'd2, 32'd50, 32'd40, 32'd5, 24'd1);
    push(1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    push(2, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
  endtask
  initial begin
    test_reset();
    test_single_up();
    test_clamp();
    test_single_down();
    test_degenerate();
    test_triangle();
    test_saw_stop();
    test_cfg_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS core. It drives the 32-bit phase-increment `Step` bus that feeds the sine, triangle and PWM wave generators, in place of the static value from the push-button clock generator. Once started, it steps the increment from a start word to a stop word in fixed increments, holding each value for a programmable dwell. It supports single up, single down, repeating sawtooth and triangle sweeps, and emits a marker pulse at each leg start to trigger a scope.

## Interface
- `WIDTH`, 32: tuning-word width; must match the `Step` bus.
- `DWELL_W`, 24: dwell counter width, in clk cycles.
- `clk`  in  1: system clock; the DDS accumulator clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: level sampled each cycle; accepted only in IDLE.
- `stop`  in  1: abort request; wins over `start` in the same cycle.
- `mode`  in  2: sweep mode. 0 = single up, 1 = single down, 2 = sawtooth (repeat up), 3 = triangle.
- `f_start`  in  WIDTH: low endpoint tuning word.
- `f_stop`  in  WIDTH: high endpoint tuning word.
- `f_delta`  in  WIDTH: increment per advance.
- `dwell`  in  DWELL_W: cycles each value is held. 0 is treated as 1.
- `step_out`  out  WIDTH: tuning word to the wave generators.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse on completion of a single sweep.
- `marker`  out  1: one-cycle pulse at the first cycle of each up-leg (sawtooth, triangle) or of the sweep (single modes).
- `cfg_err`  out  1: one-cycle pulse when `start` is rejected.

## Operation
- **States:** IDLE and RUN, plus an internal direction flag `dir_up`.
- **Reset values:** `step_out`=0, `busy`=0, `done`=0, `marker`=0, `cfg_err`=0, state IDLE, `dir_up`=1.
- **Configuration latch:** `mode`, `f_start`, `f_stop`, `f_delta` and `dwell` are latched on `start` acceptance. Input changes during RUN have no effect.
- **Start rejection:** `start` in IDLE with `f_delta`==0 or `f_start`>`f_stop` pulses `cfg_err` and stays in IDLE. `step_out` is unchanged.
- **Valid start:**
  - Enter RUN and load the dwell counter.
  - `step_out` becomes `f_stop` in mode 1, else `f_start`.
  - `dir_up` becomes 0 in mode 1, else 1.
  - `marker` pulses.
- **Advance on dwell expiry, up direction:**
  - Compute the sum in WIDTH+1 bits.
  - If `step_out`+`f_delta` ≥ `f_stop`, the next value is `f_stop`, so no wrap past the endpoint.
- **Advance on dwell expiry, down direction:**
  - If `step_out` < `f_start`+`f_delta` (WIDTH+1 bits), the next value is `f_start`.
  - Otherwise subtract.
- **Endpoint expiry (dwell ends while already at the end endpoint):**
  - Mode 0 or 1: `done` pulses and the block goes to IDLE. `step_out` holds the endpoint.
  - Mode 2: `step_out` becomes `f_start` and `marker` pulses.
  - Mode 3: `dir_up` toggles and the step moves off the endpoint by `f_delta`, clamped. `marker` pulses when turning up at `f_start`.
- **Degenerate range (`f_start`==`f_stop`):**
  - Single modes: hold for one dwell, then `done`.
  - Modes 2 and 3: `marker` repeats every dwell period.
- **`stop` in RUN:** go to IDLE next cycle. `step_out` freezes at its current value and there is no `done` pulse.
- **`start` in RUN:** ignored.
- **Reset mid-sweep:** all outputs return to reset values immediately, asynchronously.

## Timing
- **Start latency:** `start` sampled at edge 0 gives `step_out`, `busy` and `marker` valid after edge 0, i.e. on cycle 1.
- **Hold time:** each value is held for exactly D = max(`dwell`,1) cycles. Value changes occur at cycles 1+D, 1+2D, …
- **Completion (single sweep):** `done` asserts in the cycle following the final value's D cycles. `busy` drops in that same cycle.
- **Output registering:** all outputs are registered, with no combinational path from inputs to outputs.
- **Throughput:** with D=1, `step_out` changes every cycle, so the FSM must sustain one advance per cycle.

## Structure
- **Package `dds_sweep_pkg`:**
  - mode encodings `SWEEP_UP`, `SWEEP_DOWN`, `SWEEP_SAW`, `SWEEP_TRI`;
  - state type (IDLE, RUN);
  - default `WIDTH`/`DWELL_W` constants.
- **Sub-module `dwell_timer`:**
  - loadable down-counter;
  - inputs `load`, `value`;
  - output `expire`, a one-cycle pulse every D cycles while enabled;
  - maps 0 to 1.
- **Top level:** FSM, endpoint-clamp adder/subtractor and configuration registers.

## Test plan
- **Reset:** assert `reset`=0 mid-sweep → all outputs are 0 asynchronously. After release, nothing moves until `start`.
- **Single up:** mode 0, f_start=100, f_stop=130, f_delta=10, dwell=3 →
  - `step_out` sequence 100,110,120,130, each held 3 cycles;
  - `done` pulses at cycle 13;
  - `busy` is low from cycle 13.
- **Clamp:** mode 0, f_start=0, f_stop=25, f_delta=10, dwell=1 → sequence 0,10,20,25, then `done`. Also f_stop=0xFFFFFFFF, f_delta=0x80000000 → clamps to 0xFFFFFFFF with no wrap.
- **Triangle:** mode 3, 0→20, f_delta=10, dwell=2 →
  - sequence 0,10,20,10,0,10…;
  - `marker` at cycle 1 and at each return to 0;
  - `done` never pulses.
- **Stop:** `stop` during a sawtooth → `step_out` frozen, `busy`=0, `done`=0. Also `start`+`stop` together in IDLE → no start.
- **Config error:** `start` with f_delta=0, and `start` with f_start=50, f_stop=40 → `cfg_err` pulses once each and the block remains in IDLE.
